// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch-path PC sequencer: branch condition codes,
// the sequencer FSM state type and the default reset and trap vectors.
`timescale 1ns/1ps
package cpu_pkg;

   // Branch condition encodings carried on br_cond
   localparam logic [1:0] BR_EQ  = 2'd0;
   localparam logic [1:0] BR_NE  = 2'd1;
   localparam logic [1:0] BR_LTZ = 2'd2;
   localparam logic [1:0] BR_GEZ = 2'd3;

   typedef enum logic {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } pc_state_e;

   localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0080;

   // Evaluate a branch condition against the ALU flags
   function automatic logic br_cond_true(input logic [1:0] cond,
                                         input logic       zero,
                                         input logic       neg);
      logic res;
      case (cond)
         BR_EQ:   res = zero;
         BR_NE:   res = ~zero;
         BR_LTZ:  res = neg;
         default: res = ~neg;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC candidates: sequential, branch, jump, and the
// taken decision for the branch at the current pc.
`timescale 1ns/1ps
module pc_target_calc
   import cpu_pkg::*;
#(
   parameter int PC_W      = 32,
   parameter int BYTE_ADDR = 0
) (
   input  logic [PC_W-1:0] pc,
   input  logic [15:0]     imm16,
   input  logic [25:0]     imm26,
   input  logic            br_en,
   input  logic [1:0]      br_cond,
   input  logic            zero,
   input  logic            neg,
   output logic [PC_W-1:0] seq,
   output logic [PC_W-1:0] br_tgt,
   output logic [PC_W-1:0] j_tgt,
   output logic            taken
);

   localparam logic [PC_W-1:0] INC = (BYTE_ADDR != 0) ? PC_W'(4) : PC_W'(1);

   logic [PC_W-1:0] off;

   assign seq    = pc + INC;
   assign br_tgt = seq + off;
   assign taken  = br_en & br_cond_true(br_cond, zero, neg);

   // Byte mode scales offsets to words and keeps the top 4 bits of seq for
   // jumps; word mode keeps everything above the 26-bit field.
   if (BYTE_ADDR != 0) begin : g_byte
      assign off = {{(PC_W-18){imm16[15]}}, imm16, 2'b00};
      if (PC_W > 28) begin : g_hi
         assign j_tgt = {seq[PC_W-1:28], imm26, 2'b00};
      end else begin : g_nohi
         assign j_tgt = {imm26, 2'b00};
      end
   end else begin : g_word
      assign off   = {{(PC_W-16){imm16[15]}}, imm16};
      assign j_tgt = {seq[PC_W-1:26], imm26};
   end

endmodule

// File: rtl/pc_seq_unit.sv
// Next-PC generator for instruction fetch with a valid/ready handshake and a
// latched external redirect. Optional trap/eret support is compiled in when
// the macro PC_TRAP_EN is defined.
`timescale 1ns/1ps
module pc_seq_unit
   import cpu_pkg::*;
#(
   parameter int              PC_W      = 32,
   parameter int              BYTE_ADDR = 0,
   parameter logic [PC_W-1:0] RESET_VEC = DEF_RESET_VEC[PC_W-1:0]
`ifdef PC_TRAP_EN
   ,
   parameter logic [31:0]     TRAP_VEC  = DEF_TRAP_VEC
`endif
) (
   input  logic            clk,
   input  logic            reset,
   output logic [PC_W-1:0] pc,
   output logic            pc_valid,
   input  logic            pc_ready,
   input  logic [15:0]     imm16,
   input  logic [25:0]     imm26,
   input  logic            br_en,
   input  logic [1:0]      br_cond,
   input  logic            zero,
   input  logic            neg,
   input  logic            jump,
   input  logic            jr,
   input  logic [PC_W-1:0] jr_target,
   input  logic            ext_redir,
   input  logic [PC_W-1:0] ext_target,
   output logic [PC_W-1:0] link_addr,
   output logic            redir_pend
`ifdef PC_TRAP_EN
   ,
   input  logic            trap,
   input  logic            eret,
   output logic [PC_W-1:0] epc
`endif
);

   pc_state_e       state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            pc_valid_q, pc_valid_d;
   logic            redir_pend_q, redir_pend_d;
   logic [PC_W-1:0] redir_tgt_q, redir_tgt_d;
`ifdef PC_TRAP_EN
   logic [PC_W-1:0] epc_q, epc_d;
`endif

   logic [PC_W-1:0] seq, br_tgt, j_tgt;
   logic            taken;
   logic            fire;

   pc_target_calc #(
      .PC_W      (PC_W),
      .BYTE_ADDR (BYTE_ADDR)
   ) u_calc (
      .pc      (pc_q),
      .imm16   (imm16),
      .imm26   (imm26),
      .br_en   (br_en),
      .br_cond (br_cond),
      .zero    (zero),
      .neg     (neg),
      .seq     (seq),
      .br_tgt  (br_tgt),
      .j_tgt   (j_tgt),
      .taken   (taken)
   );

   assign fire       = pc_valid_q & pc_ready;
   assign pc         = pc_q;
   assign pc_valid   = pc_valid_q;
   assign redir_pend = redir_pend_q;
   assign link_addr  = seq;
`ifdef PC_TRAP_EN
   assign epc        = epc_q;
`endif

   // Next-state selection: boot handoff, fire-time pc priority, redirect latch
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pc_valid_d   = pc_valid_q;
      redir_pend_d = redir_pend_q;
      redir_tgt_d  = redir_tgt_q;
`ifdef PC_TRAP_EN
      epc_d        = epc_q;
`endif
      if (state_q == ST_BOOT) begin
         // pc is left untouched; a redirect seen now waits for the first fire
         state_d    = ST_RUN;
         pc_valid_d = 1'b1;
         if (ext_redir) begin
            redir_pend_d = 1'b1;
            redir_tgt_d  = ext_target;
         end
      end else begin
         pc_valid_d = 1'b1;
         if (fire) begin
`ifdef PC_TRAP_EN
            // trap/eret win over redirects; a same-cycle redirect is kept
            if (trap) begin
               epc_d = pc_q;
               pc_d  = TRAP_VEC[PC_W-1:0];
               if (ext_redir) begin
                  redir_pend_d = 1'b1;
                  redir_tgt_d  = ext_target;
               end
            end else if (eret) begin
               pc_d = epc_q;
               if (ext_redir) begin
                  redir_pend_d = 1'b1;
                  redir_tgt_d  = ext_target;
               end
            end else
`endif
            if (ext_redir) begin
               pc_d         = ext_target;
               redir_pend_d = 1'b0;
            end else if (redir_pend_q) begin
               pc_d         = redir_tgt_q;
               redir_pend_d = 1'b0;
            end else if (taken) begin
               pc_d = br_tgt;
            end else if (jump) begin
               pc_d = j_tgt;
            end else if (jr) begin
               pc_d = jr_target;
            end else begin
               pc_d = seq;
            end
         end else if (ext_redir) begin
            // last request wins while fetch is stalled
            redir_pend_d = 1'b1;
            redir_tgt_d  = ext_target;
         end
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= ST_BOOT;
         pc_q         <= RESET_VEC;
         pc_valid_q   <= 1'b0;
         redir_pend_q <= 1'b0;
         redir_tgt_q  <= '0;
`ifdef PC_TRAP_EN
         epc_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pc_valid_q   <= pc_valid_d;
         redir_pend_q <= redir_pend_d;
         redir_tgt_q  <= redir_tgt_d;
`ifdef PC_TRAP_EN
         epc_q        <= epc_d;
`endif
      end
   end

endmodule

// File: doc/pc_seq_unit.md
Name: pc_seq_unit

Overview:
Parametrised next-PC generator for the CPU fetch path. It generalises the single-cycle PC register in four ways: configurable PC width, a word-index or byte addressing mode, a selectable branch condition set, and a jump-register path. It adds a valid/ready handshake toward instruction fetch and a latched external redirect for debug or interrupt injection. It sits between decode/ALU (branch and jump controls) and instruction memory.

Parameters:
PC_W, 32, PC width in bits; legal range 28..32.
BYTE_ADDR, 0, 0 = word-index PC (increment 1); 1 = byte PC (increment 4, offsets shifted left by 2).
RESET_VEC, 0, PC value loaded on reset, width PC_W.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous reset, active-low; takes effect only at the rising edge of clk.
pc  out  PC_W  current fetch address.
pc_valid  out  1  pc is a valid fetch request.
pc_ready  in  1  fetch accepts pc; fire = pc_valid & pc_ready.
imm16  in  16  branch offset, sign-extended to PC_W.
imm26  in  26  jump target field.
br_en  in  1  current instruction is a branch.
br_cond  in  2  branch condition: 0 = EQ (zero), 1 = NE (!zero), 2 = LTZ (neg), 3 = GEZ (!neg).
zero  in  1  ALU zero flag.
neg  in  1  ALU sign flag.
jump  in  1  absolute jump (j/jal).
jr  in  1  jump register.
jr_target  in  PC_W  register target for jr.
ext_redir  in  1  external redirect request; single-cycle pulse.
ext_target  in  PC_W  external redirect address.
link_addr  out  PC_W  pc + INC; combinational; used by jal/jalr.
redir_pend  out  1  an external redirect is latched and not yet applied.

Behaviour:
- INC = 1 when BYTE_ADDR = 0, else 4. seq = pc + INC, modulo 2^PC_W; wraps silently.
- off = sext(imm16), additionally shifted left by 2 when BYTE_ADDR = 1. br_tgt = seq + off, modulo 2^PC_W.
- j_tgt: when BYTE_ADDR = 1, {seq[PC_W-1:28], imm26, 2'b00}. When BYTE_ADDR = 0, {seq[PC_W-1:26], imm26}.
- FSM states: BOOT, RUN.
- Reset (reset = 0 at a clock edge): state = BOOT, pc = RESET_VEC, pc_valid = 0, redir_pend = 0, pending target cleared. Reset overrides all other inputs.
- BOOT: exactly one cycle with pc_valid = 0, then go to RUN with pc_valid = 1 and pc unchanged.
- RUN: pc_valid = 1 at all times. Controls (br_en, br_cond, jump, jr, zero, neg, imm16, imm26, jr_target) refer to the instruction at pc and are sampled only on fire.
- On fire, next pc priority:
  - pending redirect (redir_pend = 1, or ext_redir = 1 in the same cycle);
  - taken branch (br_en & condition true) -> br_tgt;
  - jump -> j_tgt;
  - jr -> jr_target;
  - otherwise seq.
- No fire: pc holds. A valid request must stay stable until accepted.
- ext_redir without fire: latch ext_target and set redir_pend = 1. A later ext_redir overwrites the latched target (last wins).
- ext_redir on fire: apply ext_target directly; redir_pend stays or becomes 0.
- Applying the pending redirect clears redir_pend on that fire edge.
- ext_redir during BOOT: latched; applied on the first fire.
- Redirect latency: one fire after the request, not one cycle.

Optional Feature:
PC_TRAP_EN
- Defined: adds inputs trap (1), eret (1) and output epc (PC_W, reset 0), plus parameter TRAP_VEC (default 32'h0000_0080, truncated to PC_W).
  - trap on fire: epc <= pc, pc <= TRAP_VEC. Highest priority after reset, above pending redirect; the pending redirect stays latched.
  - eret on fire (no trap): pc <= epc, priority immediately below trap.
  - Trap and eret are ignored without fire.
- Undefined: no such ports; behaviour exactly as above.

Decomposition:
- Shared package cpu_pkg:
  - br_cond encoding constants BR_EQ, BR_NE, BR_LTZ, BR_GEZ;
  - FSM state typedef;
  - default RESET_VEC and TRAP_VEC constants.
- One natural sub-module: pc_target_calc, purely combinational. It computes seq, br_tgt, j_tgt and taken from pc and controls. The top level holds FSM, pc, pending redirect and epc registers.

Test Plan:
- Reset then pc_ready = 1, no controls, BYTE_ADDR = 0 -> pc_valid low 1 cycle; then pc = 0, 1, 2, 3. With BYTE_ADDR = 1 -> pc = 0, 4, 8, 12.
- BYTE_ADDR = 1, pc = 0x100, br_en = 1, br_cond = EQ, zero = 1, imm16 = 0xFFFE -> next pc = 0x0FC. Same stimulus with zero = 0 -> 0x104. GEZ with neg = 0 -> taken.
- pc = 0x3000_0010, BYTE_ADDR = 1, jump, imm26 = 0x0000040 -> 0x3000_0100. jr with jr_target = 0x0000_0200 -> 0x200. link_addr = 0x3000_0014 during the jump.
- pc_ready = 0 for 3 cycles with ext_redir pulse (0x400) in cycle 1 and a branch asserted -> pc holds, redir_pend = 1; on the first fire pc = 0x400 (branch ignored) and redir_pend = 0.
- reset = 0 asserted mid-run, mid-pending-redirect -> next edge pc = RESET_VEC, redir_pend = 0, pc_valid = 0. Reset asserted between edges must have no effect until the edge.
- PC_TRAP_EN: trap at pc = 0x24 -> epc = 0x24, pc = 0x80; eret on a later fire -> pc = 0x24. pc = 0xFFFF_FFFC sequential (byte mode) -> pc = 0.
